arena_map_ctrl: RTL

ARENA_MAP_CTRL -- requirements
Module: arena_map_ctrl

---
 rtl/arena_map_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/arena_map_ctrl.sv
// Arena tile map: 256x4 store, 1-cycle display read port and one round-robin shared write port.
// Optional build macro ARENA_MAP_BORDER_LOCK_EN makes border cells read-only once RUN is entered.
module arena_map_ctrl #(
  parameter logic [3:0] INIT_WALL   = 4'h1,
  parameter logic [3:0] INIT_PILLAR = 4'h2
) (
  input  logic       i_pclk,
  input  logic       i_rst,
  input  logic [7:0] i_rd_addr,
  output logic [3:0] o_rd_data,
  input  logic       i_req0,
  input  logic [7:0] i_addr0,
  input  logic [3:0] i_data0,
  input  logic       i_req1,
  input  logic [7:0] i_addr1,
  input  logic [3:0] i_data1,
  output logic       o_ack0,
  output logic       o_ack1,
  output logic       o_init_done
);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic       prio_q, prio_d;
  logic [3:0] rd_data_q;
  logic [3:0] mem_q [0:255];

  logic       we_s;
  logic [7:0] waddr_s;
  logic [3:0] wdata_s;
  logic       elig0_s;
  logic       elig1_s;

  function automatic logic is_border(input logic [7:0] a);
    return (a[3:0] == 4'h0) || (a[3:0] == 4'hF) || (a[7:4] == 4'h0) || (a[7:4] == 4'hF);
  endfunction

  function automatic logic [3:0] init_tile(input logic [7:0] a);
    logic [3:0] t;
    if (is_border(a)) begin
      t = INIT_WALL;
    end else if ((a[0] == 1'b0) && (a[4] == 1'b0)) begin
      t = INIT_PILLAR;
    end else begin
      t = 4'h0;
    end
    return t;
  endfunction

  function automatic logic write_allowed(input logic [7:0] a);
`ifdef ARENA_MAP_BORDER_LOCK_EN
    return !is_border(a);
`else
    return (a == a);
`endif
  endfunction

  // A requester whose ack is high this cycle is mid-handshake and sits out one cycle.
  assign elig0_s = i_req0 && !ack0_q;
  assign elig1_s = i_req1 && !ack1_q;

  // Next-state: init sweep, then arbitration of the shared write port
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    prio_d  = prio_q;
    we_s    = 1'b0;
    waddr_s = cnt_q;
    wdata_s = init_tile(cnt_q);
    case (state_q)
      ST_INIT: begin
        we_s  = 1'b1;
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'hFF) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        // prio_q = 1 means requester 1 wins a tie.
        if (elig0_s && (!elig1_s || !prio_q)) begin
          ack0_d  = 1'b1;
          prio_d  = 1'b1;
          we_s    = write_allowed(i_addr0);
          waddr_s = i_addr0;
          wdata_s = i_data0;
        end else if (elig1_s) begin
          ack1_d  = 1'b1;
          prio_d  = 1'b0;
          we_s    = write_allowed(i_addr1);
          waddr_s = i_addr1;
          wdata_s = i_data1;
        end else begin
          we_s = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = 8'h00;
        done_d  = 1'b0;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      state_q <= ST_INIT;
      cnt_q   <= 8'h00;
      done_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      prio_q  <= prio_d;
    end
  end

  // Map write port; reset suppresses writes so an aborted grant leaves no trace
  always_ff @(posedge i_pclk) begin
    if (we_s && !i_rst) begin
      mem_q[waddr_s] <= wdata_s;
    end
  end

  // Display read port; old contents are seen on a same-cycle write
  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      rd_data_q <= 4'h0;
    end else if (done_q) begin
      rd_data_q <= mem_q[i_rd_addr];
    end else begin
      rd_data_q <= 4'h0;
    end
  end

  assign o_rd_data   = rd_data_q;
  assign o_ack0      = ack0_q;
  assign o_ack1      = ack1_q;
  assign o_init_done = done_q;

endmodule
